fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the pipelined RV32I core: owns the PC, issues requests to instruction memory, drives the IF/ID register.
//  - Consumes from the hazard unit: stall (load-use) and flush.
//  - Consumes from EX: branch/jump redirect.
//  - Produces the IF/ID instruction the hazard unit decodes for rs1/rs2.
//  - At most one imem request outstanding; 1 instr/cycle with a zero-wait memory.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) loaded into IF/ID on flush/empty
// PORTS
//  clk                  in   1   clock; all state on posedge
//  reset_n              in   1   synchronous, active-low reset
//  IF_ID_stall_i        in   1   hazard: hold IF/ID and PC
//  IF_ID_flush_i        in   1   hazard: replace IF/ID with bubble
//  EX_pc_load_i         in   1   EX: taken branch/jump, redirect
//  EX_pc_target_i       in   32  redirect target (bits[1:0] ignored, forced 0)
//  imem_req_o           out  1   fetch request
//  imem_addr_o          out  32  fetch address, word aligned
//  imem_gnt_i           in   1   request accepted this cycle
//  imem_rvalid_i        in   1   response valid (>=1 cycle after gnt)
//  imem_rdata_i         in   32  response instruction
//  IF_ID_valid_o        out  1   IF/ID holds a real instruction
//  IF_ID_pc_o           out  32  PC of IF/ID instruction
//  IF_ID_instruction_o  out  32  instruction to ID and hazard unit
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//  - pc_q=RESET_PC, state=REQ, kill_q=0, skid empty.
//  - IF_ID_valid_o=0, IF_ID_pc_o=0, IF_ID_instruction_o=NOP_INSTR.
//  - imem_req_o forced 0 while reset_n=0.
//  - imem shares reset_n; no response arrives for a pre-reset grant.
//  FSM states: REQ (request pending), WAIT (granted, awaiting rvalid), HOLD (response parked in skid, IF/ID stalled).
//  imem_addr_o = pc_q always. imem_req_o = (REQ) | (WAIT & rvalid & !kill_q & !stall & !pc_load).
//  - Address may change while req=1 & gnt=0; memory samples only on gnt.
//  REQ:
//  - gnt -> pc_q+=4, ->WAIT.
//  - pc_load & !gnt -> pc_q=target, stay REQ.
//  - pc_load & gnt -> pc_q=target, kill_q=1, ->WAIT.
//  WAIT, no rvalid:
//  - pc_load -> pc_q=target, kill_q=1.
//  WAIT, rvalid:
//  - kill_q=1 -> drop data, kill_q=0, ->REQ.
//  - pc_load (same cycle) -> drop data, pc_q=target, ->REQ.
//  - stall -> park {pc,data} in skid, ->HOLD.
//  - otherwise -> write IF/ID; back-to-back req: gnt -> pc_q+=4, stay WAIT; !gnt -> ->REQ.
//  HOLD (req=0):
//  - pc_load -> drop skid, pc_q=target, ->REQ.
//  - !stall -> write IF/ID from skid, ->REQ.
//  IF/ID update priority, per cycle:
//  1. reset
//  2. flush | pc_load -> bubble (valid=0, NOP, pc=0)
//  3. stall -> hold
//  4. new instr (rvalid path or skid) -> valid=1
//  5. else -> bubble
//  Latency/throughput:
//  - Redirect: pc_load at cycle t -> target request issued at t+1.
//  - Zero-wait memory: 1 instr/cycle.
//  - PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
// STRUCTURE
//  riscv_pkg: NOP_INSTR, RESET_PC default, fetch state encoding (REQ/WAIT/HOLD).
//  Sub-module if_id_reg: valid/pc/instr register with stall/flush priority, reused by the ID/EX pattern.
//  fetch_stage: PC, FSM, kill flag, skid, imem interface.
// TESTING
//  1. Reset, zero-wait mem (gnt=req, rvalid next cycle)
//     -> addrs 0,4,8,... one per cycle; IF_ID_pc_o 0,4,8; first valid 2 cycles after reset release.
//  2. Stall on cycle rvalid of 0x8 arrives, held 2 cycles
//     -> skid used, IF/ID holds 0x4; no req during HOLD; 0x8 enters when stall drops; no instr lost or duplicated.
//  3. pc_load target 0x100 while WAIT on 0x10
//     -> 0x10 response dropped, next addr 0x100, IF/ID bubble for the redirect cycle.
//  4. pc_load coincident with gnt of 0x20, then rvalid
//     -> data discarded via kill_q; 0x100 fetched next.
//  5. IF_ID_flush_i & IF_ID_stall_i together
//     -> bubble (valid=0, 0x00000013) wins.
//  6. 3-cycle gnt delay + pc_load during REQ
//     -> addr switches to target before gnt; PC wraps 0xFFFFFFFC -> 0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and fetch FSM encoding shared across the RV32I pipeline
package riscv_pkg;
    localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] RV_NOP      = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, FETCH_HOLD} fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with flush > stall > load > bubble priority
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    logic        valid_d, valid_q;
    logic [31:0] pc_d, pc_q, instr_d, instr_q;

    always_comb begin
        valid_d = load_i;
        pc_d    = load_i ? pc_i : 32'h0;
        instr_d = load_i ? instr_i : NOP_INSTR;
        if (stall_i) {valid_d, pc_d, instr_d} = {valid_q, pc_q, instr_q};
        if (flush_i) {valid_d, pc_d, instr_d} = {1'b0, 32'h0, NOP_INSTR};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage - PC, single-outstanding imem request FSM, skid and IF/ID register
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RV_RESET_PC,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        IF_ID_stall_i,
    input  logic        IF_ID_flush_i,
    input  logic        EX_pc_load_i,
    input  logic [31:0] EX_pc_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        IF_ID_valid_o,
    output logic [31:0] IF_ID_pc_o,
    output logic [31:0] IF_ID_instruction_o
);
    fetch_state_e state_d, state_q;
    logic        kill_d, kill_q, fire, load;
    logic [31:0] pc_d, pc_q, rsp_pc_d, rsp_pc_q, target, load_pc, load_instr;
    logic [31:0] skid_pc_d, skid_pc_q, skid_instr_d, skid_instr_q;

    assign target      = EX_pc_target_i & ~32'h3;
    assign imem_addr_o = pc_q;
    // A fresh request may ride on a usable response only when it will be consumed this cycle
    assign imem_req_o  = reset_n & ((state_q == FETCH_REQ) |
                         ((state_q == FETCH_WAIT) & imem_rvalid_i & !kill_q & !IF_ID_stall_i & !EX_pc_load_i));
    assign fire        = imem_req_o & imem_gnt_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = fire ? pc_q + 32'd4 : pc_q;
        rsp_pc_d     = fire ? pc_q : rsp_pc_q;
        kill_d       = kill_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        load         = 1'b0;
        load_pc      = rsp_pc_q;
        load_instr   = imem_rdata_i;
        case (state_q)
            FETCH_REQ: begin
                if (fire) state_d = FETCH_WAIT;
                if (EX_pc_load_i) begin
                    pc_d   = target;
                    kill_d = fire;
                end
            end
            FETCH_WAIT: begin
                if (!imem_rvalid_i) begin
                    if (EX_pc_load_i) begin
                        pc_d   = target;
                        kill_d = 1'b1;
                    end
                end else if (kill_q | EX_pc_load_i) begin
                    kill_d  = 1'b0;
                    state_d = FETCH_REQ;
                    if (EX_pc_load_i) pc_d = target;
                end else if (IF_ID_stall_i) begin
                    skid_pc_d    = rsp_pc_q;
                    skid_instr_d = imem_rdata_i;
                    state_d      = FETCH_HOLD;
                end else begin
                    load    = 1'b1;
                    state_d = fire ? FETCH_WAIT : FETCH_REQ;
                end
            end
            FETCH_HOLD: begin
                if (EX_pc_load_i) begin
                    pc_d    = target;
                    state_d = FETCH_REQ;
                end else if (!IF_ID_stall_i) begin
                    load       = 1'b1;
                    load_pc    = skid_pc_q;
                    load_instr = skid_instr_q;
                    state_d    = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= FETCH_REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            rsp_pc_q     <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            rsp_pc_q     <= rsp_pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (IF_ID_flush_i | EX_pc_load_i),
        .stall_i (IF_ID_stall_i),
        .load_i  (load),
        .pc_i    (load_pc),
        .instr_i (load_instr),
        .valid_o (IF_ID_valid_o),
        .pc_o    (IF_ID_pc_o),
        .instr_o (IF_ID_instruction_o)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard of expected IF/ID instructions
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset_n, stall, flush, pc_load, gnt_en;
    logic [31:0] target;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        valid;
    logic [31:0] if_pc, if_instr;
    logic        pend_q = 1'b0, stall_e = 1'b0;
    logic [31:0] paddr_q = 32'h0;
    logic [31:0] exp_q[$];
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .IF_ID_stall_i       (stall),
        .IF_ID_flush_i       (flush),
        .EX_pc_load_i        (pc_load),
        .EX_pc_target_i      (target),
        .imem_req_o          (imem_req),
        .imem_addr_o         (imem_addr),
        .imem_gnt_i          (imem_gnt),
        .imem_rvalid_i       (imem_rvalid),
        .imem_rdata_i        (imem_rdata),
        .IF_ID_valid_o       (valid),
        .IF_ID_pc_o          (if_pc),
        .IF_ID_instruction_o (if_instr)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    // Memory: grant while gnt_en, respond exactly one cycle after grant
    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend_q;
    assign imem_rdata  = memf(paddr_q);

    always @(posedge clk) begin
        stall_e <= stall;
        if (!reset_n) pend_q <= 1'b0;
        else begin
            pend_q <= imem_req & imem_gnt;
            if (imem_req & imem_gnt) paddr_q <= imem_addr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A new IF/ID entry is any valid value after an edge without stall
    always @(negedge clk) begin
        if (valid && !stall_e) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc %h, none expected", if_pc);
            end else begin
                check("if_id_pc", if_pc, exp_q[0]);
                check("if_id_instr", if_instr, memf(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        pc_load = 1'b0;
        target  = 32'h0;
        gnt_en  = 1'b1;
        exp_q.delete();
        cyc(2);
    endtask

    task automatic wait_gnt(input logic [31:0] a);
        int k = 0;
        while (!(imem_req && imem_gnt && imem_addr == a) && k < 40) begin
            cyc();
            k++;
        end
        check("gnt_seen", {31'd0, imem_req && imem_gnt && imem_addr == a}, 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            cyc();
            k++;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state and zero-wait streaming, then a 2-cycle stall into the skid
        do_reset();
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", valid, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'h13);
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
        reset_n = 1'b1;
        #1 check("t1_addr0", imem_addr, 32'h0);
        cyc();
        check("t1_addr1", imem_addr, 32'h4);
        check("t1_valid1", valid, 32'd0);
        cyc();
        check("t1_valid2", valid, 32'd1);
        check("t1_addr2", imem_addr, 32'h8);
        wait_gnt(32'h8);
        cyc();
        stall = 1'b1;
        #1 check("t2_req_stall", imem_req, 32'd0);
        cyc();
        check("t2_req_hold", imem_req, 32'd0);
        check("t2_ifid_held", if_pc, 32'h4);
        cyc();
        stall = 1'b0;
        #1 check("t2_req_release", imem_req, 32'd0);
        wait_gnt(32'hC);
        cyc();
        gnt_en = 1'b0;
        drain();

        // Redirect on the cycle the 0x10 response arrives
        do_reset();
        exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
        reset_n = 1'b1;
        wait_gnt(32'h10);
        cyc();
        pc_load = 1'b1;
        target  = 32'h103;
        #1 check("t3_req_redirect", imem_req, 32'd0);
        cyc();
        pc_load = 1'b0;
        #1 check("t3_bubble_valid", valid, 32'd0);
        check("t3_bubble_instr", if_instr, 32'h13);
        check("t3_target_addr", imem_addr, 32'h100);
        check("t3_target_req", imem_req, 32'd1);
        wait_gnt(32'h104);
        cyc();
        gnt_en = 1'b0;
        drain();

        // Redirect coincident with the grant of 0x20
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        exp_q.push_back(32'h100);
        reset_n = 1'b1;
        wait_gnt(32'h1C);
        cyc();
        gnt_en = 1'b0;
        cyc();
        gnt_en  = 1'b1;
        pc_load = 1'b1;
        target  = 32'h100;
        #1 check("t4_gnt_0x20", {31'd0, imem_gnt && imem_addr == 32'h20}, 32'd1);
        cyc();
        pc_load = 1'b0;
        #1 check("t4_req_killed", imem_req, 32'd0);
        cyc();
        check("t4_next_addr", imem_addr, 32'h100);
        wait_gnt(32'h100);
        cyc();
        gnt_en = 1'b0;
        drain();

        // Flush and stall together: bubble wins, parked 0x8 still delivered
        do_reset();
        exp_q = {32'h0, 32'h4, 32'h8};
        reset_n = 1'b1;
        wait_gnt(32'h8);
        cyc();
        flush = 1'b1;
        stall = 1'b1;
        cyc();
        check("t5_valid", valid, 32'd0);
        check("t5_instr", if_instr, 32'h13);
        check("t5_pc", if_pc, 32'h0);
        flush  = 1'b0;
        stall  = 1'b0;
        gnt_en = 1'b0;
        drain();

        // Delayed grant, redirect while REQ, PC wrap
        do_reset();
        gnt_en = 1'b0;
        exp_q = {32'hFFFF_FFFC};
        reset_n = 1'b1;
        pc_load = 1'b1;
        target  = 32'hFFFF_FFFC;
        #1 check("t6_req_pending", imem_req, 32'd1);
        cyc();
        pc_load = 1'b0;
        #1 check("t6_addr_switch", imem_addr, 32'hFFFF_FFFC);
        check("t6_req_held", imem_req, 32'd1);
        cyc();
        check("t6_addr_stable", imem_addr, 32'hFFFF_FFFC);
        cyc();
        gnt_en = 1'b1;
        cyc();
        check("t6_wrap_addr", imem_addr, 32'h0);
        gnt_en = 1'b0;
        drain();
        check("t6_wrap_req", imem_req, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
